// File: rtl/spart_pkg.sv
// Shared definitions for the SPART processor-bus responder:
// register map, status bit positions, TX hand-off states and the reset divisor.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam int STAT_RDA    = 0;
    localparam int STAT_TBR    = 1;
    localparam int STAT_RXOVR  = 2;
    localparam int STAT_TXDROP = 3;

    localparam logic [15:0] DIV_RESET_DEFAULT = 16'd325;

    typedef enum logic [1:0] {
        TX_EMPTY = 2'b00,
        TX_FULL  = 2'b01,
        TX_LOAD  = 2'b10
    } tx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// 16x oversample enable generator: a down counter that pulses baud_en at zero
// and reloads from the divisor, or immediately when the divisor is rewritten.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic        reload,
    output logic        baud_en
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        // NOTE: give every always_comb target a default first so no latch is inferred.
        cnt_d = cnt_q - 16'd1;
        if (reload || (cnt_q == '0)) begin
            cnt_d = divisor;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            cnt_q <= DIV_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign baud_en = (cnt_q == '0);

endmodule

// File: rtl/spart_bus_intf.sv
// SPART bus responder: register decode, zero-latency read mux, RX buffer, TX hand-off FSM.
// Define SPART_STATUS_ERR_EN to build the sticky rxovr/txdrop status flags.
module spart_bus_intf
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iocs,
    input  logic              iorw,
    input  logic [1:0]        ioaddr,
    inout  wire  [DATA_W-1:0] databus,
    output logic              rda,
    output logic              tbr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    input  logic              tx_busy,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              baud_en
);

    logic rd_cyc;
    logic wr_cyc;
    logic rd_data_reg;
    logic wr_data_reg;
    logic wr_div_lo;
    logic wr_div_hi;
    logic tx_accept;

    logic [DATA_W-1:0] rx_buf_q,  rx_buf_d;
    logic              rda_q,     rda_d;
    logic [15:0]       divisor_q, divisor_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    tx_state_t         tx_state_q, tx_state_d;

    logic              rxovr;
    logic              txdrop;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rd_data;

    assign rd_cyc      = iocs &  iorw;
    assign wr_cyc      = iocs & ~iorw;
    assign rd_data_reg = rd_cyc && (ioaddr == ADDR_DATA);
    assign wr_data_reg = wr_cyc && (ioaddr == ADDR_DATA);
    assign wr_div_lo   = wr_cyc && (ioaddr == ADDR_DB_LO);
    assign wr_div_hi   = wr_cyc && (ioaddr == ADDR_DB_HI);
    assign tx_accept   = wr_data_reg && (tx_state_q == TX_EMPTY);

    // A new byte in the same cycle as a data read keeps rda set: the read saw the old byte.
    always_comb begin
        rx_buf_d  = rx_buf_q;
        rda_d     = rda_q;
        divisor_d = divisor_q;
        tx_data_d = tx_data_q;
        if (rd_data_reg) begin
            rda_d = 1'b0;
        end
        if (rx_valid) begin
            rx_buf_d = rx_data;
            rda_d    = 1'b1;
        end
        if (tx_accept) begin
            tx_data_d = databus;
        end
        if (wr_div_lo) begin
            divisor_d[7:0] = databus;
        end
        if (wr_div_hi) begin
            divisor_d[15:8] = databus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_buf_q  <= '0;
            rda_q     <= 1'b0;
            divisor_q <= DIV_RESET;
            tx_data_q <= '0;
        end else begin
            rx_buf_q  <= rx_buf_q == rx_buf_d ? rx_buf_q : rx_buf_d;
            rda_q     <= rda_d;
            divisor_q <= divisor_d;
            tx_data_q <= tx_data_d;
        end
    end

`ifdef SPART_STATUS_ERR_EN
    logic rd_status;
    logic rxovr_q, rxovr_d;
    logic txdrop_q, txdrop_d;

    assign rd_status = rd_cyc && (ioaddr == ADDR_STATUS);

    // Clear-on-read comes first so a same-cycle set event wins.
    always_comb begin
        rxovr_d  = rxovr_q;
        txdrop_d = txdrop_q;
        if (rd_status) begin
            rxovr_d  = 1'b0;
            txdrop_d = 1'b0;
        end
        if (rx_valid && rda_q && !rd_data_reg) begin
            rxovr_d = 1'b1;
        end
        if (wr_data_reg && (tx_state_q != TX_EMPTY)) begin
            txdrop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxovr_q  <= 1'b0;
            txdrop_q <= 1'b0;
        end else begin
            rxovr_q  <= rxovr_d;
            txdrop_q <= txdrop_d;
        end
    end

    assign rxovr  = rxovr_q;
    assign txdrop = txdrop_q;
`else
    assign rxovr  = 1'b0;
    assign txdrop = 1'b0;
`endif

    // TX hand-off FSM: state register, next-state logic, output decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_EMPTY;
        end else begin
            tx_state_q <= tx_state_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_EMPTY: if (wr_data_reg) tx_state_d = TX_FULL;
            TX_FULL:  if (!tx_busy)    tx_state_d = TX_LOAD;
            TX_LOAD:  tx_state_d = TX_EMPTY;
            default:  tx_state_d = TX_EMPTY;
        endcase
    end

    always_comb begin
        tbr     = (tx_state_q == TX_EMPTY);
        tx_load = (tx_state_q == TX_LOAD);
    end

    always_comb begin
        status              = '0;
        status[STAT_RDA]    = rda_q;
        status[STAT_TBR]    = tbr;
        status[STAT_RXOVR]  = rxovr;
        status[STAT_TXDROP] = txdrop;
    end

    always_comb begin
        rd_data = '0;
        case (ioaddr)
            ADDR_DATA:   rd_data = rx_buf_q;
            ADDR_STATUS: rd_data = status;
            ADDR_DB_LO:  rd_data = divisor_q[7:0];
            ADDR_DB_HI:  rd_data = divisor_q[15:8];
            default:     rd_data = '0;
        endcase
    end

    assign databus = rd_cyc ? rd_data : 'z;

    assign rda     = rda_q;
    assign tx_data = tx_data_q;

    spart_baud_gen #(
        .DIV_RESET (DIV_RESET)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .divisor (divisor_d),
        .reload  (wr_div_lo | wr_div_hi),
        .baud_en (baud_en)
    );

endmodule

// File: tb/tb_spart_bus_intf.sv
// Self-checking bench for spart_bus_intf: directed scenarios plus randomized bus
// traffic compared every cycle against a behavioural model of the register rules.
module tb_spart_bus_intf;
    import spart_pkg::*;

`ifdef SPART_STATUS_ERR_EN
    localparam logic [7:0] STAT_KEEP = 8'hFF;
`else
    localparam logic [7:0] STAT_KEEP = 8'hF3;
`endif

    logic       clk;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] tb_bus;
    logic       tb_drive;
    logic       rda;
    logic       tbr;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       baud_en;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  m_rx_buf;
    logic [7:0]  m_tx_data;
    logic        m_rda;
    logic        m_ovr;
    logic        m_drop;
    logic        m_tx_full;
    logic        m_tx_loading;
    logic [15:0] m_div;
    int          m_k;

    assign databus = tb_drive ? tb_bus : 8'hzz;

    spart_bus_intf dut (
        .clk      (clk),
        .rst      (rst),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rda      (rda),
        .tbr      (tbr),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .baud_en  (baud_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic exp_tbr();
        return !(m_tx_full || m_tx_loading);
    endfunction

    // Cycle k after the last reload pulses when k is a multiple of divisor+1.
    function automatic logic exp_baud();
        return (m_k % (int'(m_div) + 1)) == 0;
    endfunction

    function automatic logic [7:0] exp_status();
        logic [7:0] s;
        s    = 8'h00;
        s[0] = m_rda;
        s[1] = exp_tbr();
        s[2] = m_ovr;
        s[3] = m_drop;
        return s & STAT_KEEP;
    endfunction

    function automatic logic [7:0] exp_read(input logic [1:0] a);
        case (a)
            2'b00:   return m_rx_buf;
            2'b01:   return exp_status();
            2'b10:   return m_div[7:0];
            default: return m_div[15:8];
        endcase
    endfunction

    task automatic model_reset();
        m_rx_buf     = 8'h00;
        m_tx_data    = 8'h00;
        m_rda        = 1'b0;
        m_ovr        = 1'b0;
        m_drop       = 1'b0;
        m_tx_full    = 1'b0;
        m_tx_loading = 1'b0;
        m_div        = 16'd325;
        m_k          = 1;
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic advance();
        logic rd0, rd1, wr0, wrlo, wrhi, was_empty;
        if (rst) begin
            model_reset();
            return;
        end
        rd0       = iocs && iorw  && (ioaddr == 2'b00);
        rd1       = iocs && iorw  && (ioaddr == 2'b01);
        wr0       = iocs && !iorw && (ioaddr == 2'b00);
        wrlo      = iocs && !iorw && (ioaddr == 2'b10);
        wrhi      = iocs && !iorw && (ioaddr == 2'b11);
        was_empty = exp_tbr();
        if (rd1) begin
            m_ovr  = 1'b0;
            m_drop = 1'b0;
        end
        if (rx_valid && m_rda && !rd0) m_ovr = 1'b1;
        if (wr0 && !was_empty) m_drop = 1'b1;
        if (rd0) m_rda = 1'b0;
        if (rx_valid) begin
            m_rx_buf = rx_data;
            m_rda    = 1'b1;
        end
        if (m_tx_loading) begin
            m_tx_loading = 1'b0;
        end else if (m_tx_full && !tx_busy) begin
            m_tx_full    = 1'b0;
            m_tx_loading = 1'b1;
        end
        if (wr0 && was_empty) begin
            m_tx_full = 1'b1;
            m_tx_data = tb_bus;
        end
        if (wrlo) m_div[7:0]  = tb_bus;
        if (wrhi) m_div[15:8] = tb_bus;
        if (wrlo || wrhi) m_k = 1;
        else              m_k = m_k + 1;
    endtask

    task automatic apply(input logic cs, input logic rw, input logic [1:0] a,
                         input logic [7:0] wd, input logic rxv, input logic [7:0] rxd,
                         input logic busy);
        @(negedge clk);
        rst      = 1'b0;
        iocs     = cs;
        iorw     = rw;
        ioaddr   = a;
        tb_bus   = wd;
        tb_drive = cs && !rw;
        rx_valid = rxv;
        rx_data  = rxd;
        tx_busy  = busy;
        #1;
    endtask

    task automatic idle(input logic busy);
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, busy);
        advance();
    endtask

    task automatic do_reset(input logic busy);
        @(negedge clk);
        rst      = 1'b1;
        iocs     = 1'b0;
        iorw     = 1'b0;
        ioaddr   = 2'b00;
        tb_drive = 1'b0;
        rx_valid = 1'b0;
        tx_busy  = busy;
        #1;
        advance();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if ({rda, tbr, tx_load, baud_en} !== 4'b0100) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0100", {rda, tbr, tx_load, baud_en});
        end
        n_vec++;
        if (tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_tx_data: got %h want 00", tx_data);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_STATUS, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== 8'h02) begin
            n_err++;
            $display("FAIL reset_status: got %h want 02", databus);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_DB_LO, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== 8'h45) begin
            n_err++;
            $display("FAIL reset_div_lo: got %h want 45", databus);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_DB_HI, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== 8'h01) begin
            n_err++;
            $display("FAIL reset_div_hi: got %h want 01", databus);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_DATA, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== 8'h00) begin
            n_err++;
            $display("FAIL reset_rx_buf: got %h want 00", databus);
        end
        advance();
    endtask

    task automatic test_baud();
        logic [7:0] d;
        for (int r = 0; r < 4; r++) begin
            d = (r == 0) ? 8'd3 : ((r == 1) ? 8'd0 : 8'($urandom_range(1, 9)));
            apply(1'b1, 1'b0, ADDR_DB_LO, d, 1'b0, 8'h00, 1'b0);
            advance();
            apply(1'b1, 1'b0, ADDR_DB_HI, 8'h00, 1'b0, 8'h00, 1'b0);
            advance();
            for (int k = 1; k <= 2 * (int'(d) + 1) + 2; k++) begin
                apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
                n_vec++;
                if (baud_en !== ((k % (int'(d) + 1)) == 0)) begin
                    n_err++;
                    $display("FAIL baud_div%0d_cyc%0d: got %b want %b", d, k, baud_en,
                             (k % (int'(d) + 1)) == 0);
                end
                advance();
            end
            apply(1'b1, 1'b1, ADDR_DB_LO, 8'h00, 1'b0, 8'h00, 1'b0);
            n_vec++;
            if (databus !== d) begin
                n_err++;
                $display("FAIL baud_readback: got %h want %h", databus, d);
            end
            advance();
        end
    endtask

    task automatic test_tx_basic();
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            apply(1'b1, 1'b0, ADDR_DATA, b, 1'b0, 8'h00, 1'b0);
            advance();
            apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
            n_vec++;
            if ({tbr, tx_load} !== 2'b00) begin
                n_err++;
                $display("FAIL tx_full_flags: got %b want 00", {tbr, tx_load});
            end
            advance();
            apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
            n_vec++;
            if ({tbr, tx_load, tx_data} !== {2'b01, b}) begin
                n_err++;
                $display("FAIL tx_load_pulse: got %b_%h want 01_%h", {tbr, tx_load}, tx_data, b);
            end
            advance();
            apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
            n_vec++;
            if ({tbr, tx_load} !== 2'b10) begin
                n_err++;
                $display("FAIL tx_back_empty: got %b want 10", {tbr, tx_load});
            end
            advance();
        end
    endtask

    task automatic test_tx_drop();
        apply(1'b1, 1'b0, ADDR_DATA, 8'h11, 1'b0, 8'h00, 1'b1);
        advance();
        apply(1'b1, 1'b0, ADDR_DATA, 8'h22, 1'b0, 8'h00, 1'b1);
        advance();
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b1);
        n_vec++;
        if ({tbr, tx_load, tx_data} !== {2'b00, 8'h11}) begin
            n_err++;
            $display("FAIL tx_drop_hold: got %b_%h want 00_11", {tbr, tx_load}, tx_data);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_STATUS, 8'h00, 1'b0, 8'h00, 1'b1);
        n_vec++;
        if (databus !== (8'h08 & STAT_KEEP)) begin
            n_err++;
            $display("FAIL tx_drop_status: got %h want %h", databus, 8'h08 & STAT_KEEP);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_STATUS, 8'h00, 1'b0, 8'h00, 1'b1);
        n_vec++;
        if (databus !== 8'h00) begin
            n_err++;
            $display("FAIL tx_drop_cleared: got %h want 00", databus);
        end
        advance();
        idle(1'b0);
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if ({tx_load, tx_data} !== {1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL tx_drop_release: got %b_%h want 1_11", tx_load, tx_data);
        end
        advance();
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if ({tbr, tx_load} !== 2'b10) begin
            n_err++;
            $display("FAIL tx_drop_done: got %b want 10", {tbr, tx_load});
        end
        advance();
    endtask

    task automatic test_rx();
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'h3C, 1'b0);
        advance();
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (rda !== 1'b1) begin
            n_err++;
            $display("FAIL rx_rda_set: got %b want 1", rda);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_DATA, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== 8'h3C) begin
            n_err++;
            $display("FAIL rx_read: got %h want 3c", databus);
        end
        advance();
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (rda !== 1'b0) begin
            n_err++;
            $display("FAIL rx_rda_clear: got %b want 0", rda);
        end
        advance();
        // Overrun: two bytes with no read in between
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'h01, 1'b0);
        advance();
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'h02, 1'b0);
        advance();
        apply(1'b1, 1'b1, ADDR_STATUS, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== (8'h07 & STAT_KEEP)) begin
            n_err++;
            $display("FAIL rx_ovr_status: got %h want %h", databus, 8'h07 & STAT_KEEP);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_DATA, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== 8'h02) begin
            n_err++;
            $display("FAIL rx_ovr_data: got %h want 02", databus);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_STATUS, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== 8'h02) begin
            n_err++;
            $display("FAIL rx_ovr_cleared: got %h want 02", databus);
        end
        advance();
        // New byte arriving in the same cycle as a data read
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'hAA, 1'b0);
        advance();
        apply(1'b1, 1'b1, ADDR_DATA, 8'h00, 1'b1, 8'h55, 1'b0);
        n_vec++;
        if (databus !== 8'hAA) begin
            n_err++;
            $display("FAIL rx_same_cycle_old: got %h want aa", databus);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_DATA, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if ({rda, databus} !== {1'b1, 8'h55}) begin
            n_err++;
            $display("FAIL rx_same_cycle_new: got %b_%h want 1_55", rda, databus);
        end
        advance();
        // Overrun set in the same cycle as a status read: the set wins
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'h10, 1'b0);
        advance();
        apply(1'b1, 1'b1, ADDR_STATUS, 8'h00, 1'b1, 8'h20, 1'b0);
        n_vec++;
        if (databus !== 8'h03) begin
            n_err++;
            $display("FAIL rx_setwins_first: got %h want 03", databus);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_STATUS, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== (8'h07 & STAT_KEEP)) begin
            n_err++;
            $display("FAIL rx_setwins_second: got %h want %h", databus, 8'h07 & STAT_KEEP);
        end
        advance();
        apply(1'b1, 1'b1, ADDR_DATA, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== 8'h20) begin
            n_err++;
            $display("FAIL rx_setwins_data: got %h want 20", databus);
        end
        advance();
    endtask

    task automatic test_reset_abort();
        apply(1'b1, 1'b0, ADDR_DATA, 8'h5A, 1'b0, 8'h00, 1'b1);
        advance();
        idle(1'b1);
        do_reset(1'b1);
        apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if ({rda, tbr, tx_load, tx_data} !== {3'b010, 8'h00}) begin
            n_err++;
            $display("FAIL abort_state: got %b_%h want 010_00", {rda, tbr, tx_load}, tx_data);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
            n_vec++;
            if (tx_load !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_load: got %b want 0", tx_load);
            end
            advance();
        end
        apply(1'b1, 1'b1, ADDR_DB_LO, 8'h00, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if (databus !== 8'h45) begin
            n_err++;
            $display("FAIL abort_div_lo: got %h want 45", databus);
        end
        advance();
    endtask

    task automatic test_random();
        logic       cs, rw, rxv, busy;
        logic [1:0] a;
        logic [7:0] wd, rxd;
        for (int i = 0; i < 600; i++) begin
            cs   = 1'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            a    = 2'($urandom_range(0, 3));
            wd   = 8'($urandom);
            if (a == ADDR_DB_LO) wd = wd & 8'h0F;
            if (a == ADDR_DB_HI) wd = 8'h00;
            rxv  = ($urandom_range(0, 3) == 0);
            rxd  = 8'($urandom);
            busy = ($urandom_range(0, 2) == 0);
            apply(cs, rw, a, wd, rxv, rxd, busy);
            n_vec++;
            if ({rda, tbr, tx_load, baud_en, tx_data} !==
                {m_rda, exp_tbr(), m_tx_loading, exp_baud(), m_tx_data}) begin
                n_err++;
                $display("FAIL rand_outputs cyc%0d: got %b_%h want %b_%h", i,
                         {rda, tbr, tx_load, baud_en}, tx_data,
                         {m_rda, exp_tbr(), m_tx_loading, exp_baud()}, m_tx_data);
            end
            if (cs && rw) begin
                n_vec++;
                if (databus !== exp_read(a)) begin
                    n_err++;
                    $display("FAIL rand_read cyc%0d addr%0d: got %h want %h", i, a, databus,
                             exp_read(a));
                end
            end
            advance();
        end
    endtask

    initial begin
        rst      = 1'b1;
        iocs     = 1'b0;
        iorw     = 1'b0;
        ioaddr   = 2'b00;
        tb_bus   = 8'h00;
        tb_drive = 1'b0;
        tx_busy  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        model_reset();
        test_reset();
        test_baud();
        test_tx_basic();
        test_tx_drop();
        test_rx();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
